// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM states and the buffered fetch entry layout.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_RESP,
      ST_DROP
   } state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_entry_t;

   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Signal bundle between the fetch unit, PC register, memory and decode.
// master is the fetch unit side, slave is its environment.
interface instr_fetch_if;

   logic [31:0] pc;
   logic        pc_write_enable;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_fault;

   modport master (
      input  pc, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
      output pc_write_enable, imem_req, imem_addr,
      output if_valid, if_instr, if_pc, if_fault
   );

   modport slave (
      output pc, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
      input  pc_write_enable, imem_req, imem_addr,
      input  if_valid, if_instr, if_pc, if_fault
   );

endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous buffer of fetched entries between memory and decode.
// clear wins over push/pop; push into a full FIFO succeeds when a pop coincides.
module fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          push_i,
   input  fetch_entry_t  data_i,
   input  logic          pop_i,
   output fetch_entry_t  head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Depth is a power of two, so pointers wrap naturally.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PW'(1);
         if (do_pop)  rd_d = rd_q + PW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with a small decode buffer.
// Define INSTR_FETCH_ALIGN_CHECK_EN to turn misaligned PCs into fault entries.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input logic          clk,
   input logic          reset,
   instr_fetch_if.master bus
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   state_e       state_q, state_d;
   logic [31:0]  pending_pc_q, pending_pc_d;
   logic         req_c, grant, push, pop, room, outstanding;
   fetch_entry_t push_data, head;
   logic         full, empty;
   logic [CW-1:0] count;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   logic fault_q, fault_d;
`endif

   assign outstanding = (state_q != ST_REQ);
   assign room = ({1'b0, count} + (CW+1)'(outstanding))
               < (CW+1)'(FIFO_DEPTH);
   assign grant = req_c & bus.imem_gnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_REQ;
         pending_pc_q <= '0;
      end else begin
         state_q      <= state_d;
         pending_pc_q <= pending_pc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pending_pc_d = grant ? bus.pc : pending_pc_q;
      unique case (state_q)
         ST_REQ:  if (grant) state_d = ST_RESP;
         ST_RESP: begin
            if (bus.imem_rvalid)  state_d = ST_REQ;
            else if (bus.flush)   state_d = ST_DROP;
         end
         ST_DROP: if (bus.imem_rvalid) state_d = ST_REQ;
         default: state_d = ST_REQ;
      endcase
   end

   // A misaligned PC queues one fault entry, then idles until redirected.
   always_comb begin
      req_c     = 1'b0;
      push      = 1'b0;
      push_data = '{pc: pending_pc_q, instr: bus.imem_rdata, fault: 1'b0};
      unique case (state_q)
         ST_REQ: begin
            if (!reset && !bus.flush) begin
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
               if (bus.pc[1:0] != 2'b00) begin
                  push      = ~fault_q & room;
                  push_data = '{pc: bus.pc, instr: NOP, fault: 1'b1};
               end else
`endif
               req_c = room;
            end
         end
         ST_RESP: push = bus.imem_rvalid & ~reset;
         default: ;
      endcase
   end

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   always_comb begin
      fault_d = fault_q;
      if (bus.flush)                  fault_d = 1'b0;
      else if (push && push_data.fault) fault_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) fault_q <= 1'b0;
      else       fault_q <= fault_d;
   end
`endif

   assign pop = ~empty & bus.if_ready;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear_i (bus.flush),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   logic unused_full;
   assign unused_full = full;

   assign bus.imem_req        = req_c;
   assign bus.imem_addr       = word_addr(bus.pc);
   assign bus.pc_write_enable = grant | (bus.flush & ~reset);

   assign bus.if_valid = ~empty;
   assign bus.if_instr = empty ? NOP : head.instr;
   assign bus.if_pc    = empty ? RESET_PC : head.pc;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   assign bus.if_fault = ~empty & head.fault;
`else
   logic unused_fault;
   assign unused_fault = head.fault;
   assign bus.if_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, then random traffic
// against a memory-level model of expected decode output.
module tb_instr_fetch;

   localparam int DEPTH = 2;
   localparam logic [31:0] RPC = 32'h0040_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   instr_fetch_if bus();

   instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic r, f, g, v, y,
                      input logic [31:0] p, d);
      @(negedge clk);
      reset           = r;
      bus.flush       = f;
      bus.imem_gnt    = g;
      bus.imem_rvalid = v;
      bus.if_ready    = y;
      bus.pc          = p;
      bus.imem_rdata  = d;
      #1;
   endtask

   logic [31:0] q_pc[$];
   logic [31:0] q_in[$];
   logic [31:0] pc_reg, mem_pc, rd;
   logic        mem_out, mem_drop, f, g, v, y, exp_req;

   initial begin
      bus.flush = 0; bus.imem_gnt = 0; bus.imem_rvalid = 0;
      bus.if_ready = 0; bus.pc = RPC; bus.imem_rdata = 0;

      // reset cycle: even with flush and gnt high, no strobes
      drv(1, 1, 1, 0, 0, RPC, 0);
      chk("rst_req", bus.imem_req, 0);
      chk("rst_pwe", bus.pc_write_enable, 0);
      drv(1, 0, 0, 0, 0, RPC, 0);
      chk("rst_valid", bus.if_valid, 0);
      chk("rst_pc", bus.if_pc, RPC);
      chk("rst_instr", bus.if_instr, 0);
      chk("rst_fault", bus.if_fault, 0);

      // basic fetch, two-cycle grant-to-valid
      drv(0, 0, 1, 0, 0, 32'h0040_0000, 0);
      chk("f1_req", bus.imem_req, 1);
      chk("f1_addr", bus.imem_addr, 32'h0040_0000);
      chk("f1_pwe", bus.pc_write_enable, 1);
      drv(0, 0, 0, 1, 0, 32'h0040_0004, 32'h2008_0005);
      chk("f1_resp_req", bus.imem_req, 0);
      chk("f1_resp_pwe", bus.pc_write_enable, 0);
      chk("f1_nobypass", bus.if_valid, 0);
      drv(0, 0, 1, 0, 0, 32'h0040_0004, 0);
      chk("f1_valid", bus.if_valid, 1);
      chk("f1_pc", bus.if_pc, 32'h0040_0000);
      chk("f1_instr", bus.if_instr, 32'h2008_0005);
      chk("f2_req", bus.imem_req, 1);
      chk("f2_pwe", bus.pc_write_enable, 1);

      // backpressure fills the buffer
      drv(0, 0, 0, 1, 0, 32'h0040_0008, 32'h1111_1111);
      drv(0, 0, 1, 0, 0, 32'h0040_0008, 0);
      chk("full_req", bus.imem_req, 0);
      chk("full_pwe", bus.pc_write_enable, 0);
      drv(0, 0, 0, 0, 1, 32'h0040_0008, 0);
      chk("pop_req", bus.imem_req, 0);
      chk("pop_pc", bus.if_pc, 32'h0040_0000);
      drv(0, 0, 1, 0, 0, 32'h0040_0008, 0);
      chk("reass_req", bus.imem_req, 1);
      chk("reass_addr", bus.imem_addr, 32'h0040_0008);
      chk("head2_pc", bus.if_pc, 32'h0040_0004);
      chk("head2_instr", bus.if_instr, 32'h1111_1111);
      drv(0, 0, 0, 1, 0, 32'h0040_000c, 32'h2222_2222);

      // flush on a full buffer with pop and a stray response
      drv(0, 1, 1, 1, 1, 32'h0040_000c, 32'hdead_beef);
      chk("fl_req", bus.imem_req, 0);
      chk("fl_pwe", bus.pc_write_enable, 1);
      chk("fl_valid", bus.if_valid, 1);
      drv(0, 0, 1, 0, 0, 32'h0050_0000, 0);
      chk("fl_empty", bus.if_valid, 0);
      chk("fl_idle_pc", bus.if_pc, RPC);
      chk("fl_req2", bus.imem_req, 1);
      chk("fl_addr", bus.imem_addr, 32'h0050_0000);

      // flush while response pending, late response dropped
      drv(0, 1, 1, 0, 0, 32'h0050_0004, 0);
      chk("dr_req", bus.imem_req, 0);
      chk("dr_pwe", bus.pc_write_enable, 1);
      drv(0, 0, 1, 0, 0, 32'h0060_0000, 0);
      chk("dr_wait_req", bus.imem_req, 0);
      chk("dr_wait_pwe", bus.pc_write_enable, 0);
      drv(0, 0, 1, 0, 0, 32'h0060_0000, 0);
      chk("dr_wait2_req", bus.imem_req, 0);
      drv(0, 0, 1, 1, 0, 32'h0060_0000, 32'hdead_beef);
      chk("dr_rv_req", bus.imem_req, 0);
      drv(0, 0, 1, 0, 0, 32'h0060_0000, 0);
      chk("dr_novalid", bus.if_valid, 0);
      chk("dr_req_new", bus.imem_req, 1);
      chk("dr_addr", bus.imem_addr, 32'h0060_0000);

      // reset mid-transaction, stray response ignored
      drv(1, 0, 0, 0, 0, 32'h0060_0004, 0);
      chk("mr_req", bus.imem_req, 0);
      chk("mr_pwe", bus.pc_write_enable, 0);
      drv(0, 0, 0, 1, 0, 32'h0060_0004, 32'hdead_beef);
      chk("mr_req2", bus.imem_req, 1);
      drv(0, 0, 1, 0, 0, 32'h0060_0004, 0);
      chk("mr_stray", bus.if_valid, 0);
      chk("mr_idle_pc", bus.if_pc, RPC);
      chk("mr_addr", bus.imem_addr, 32'h0060_0004);
      drv(0, 0, 0, 1, 0, 32'h0060_0008, 32'h3333_3333);
      drv(0, 0, 0, 0, 1, 32'h0060_0008, 0);
      chk("mr_pc", bus.if_pc, 32'h0060_0004);
      chk("mr_instr", bus.if_instr, 32'h3333_3333);

      // misaligned pc
      drv(0, 0, 1, 0, 0, 32'h0060_0006, 0);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
      chk("mis_req", bus.imem_req, 0);
      chk("mis_pwe", bus.pc_write_enable, 0);
      drv(0, 0, 1, 0, 0, 32'h0060_0006, 0);
      chk("mis_valid", bus.if_valid, 1);
      chk("mis_fault", bus.if_fault, 1);
      chk("mis_instr", bus.if_instr, 0);
      chk("mis_pc", bus.if_pc, 32'h0060_0006);
      drv(0, 0, 1, 0, 1, 32'h0060_0006, 0);
      chk("mis_stay", bus.imem_req, 0);
      drv(0, 0, 1, 0, 0, 32'h0060_0006, 0);
      chk("mis_once", bus.if_valid, 0);
`else
      chk("mis_req", bus.imem_req, 1);
      chk("mis_addr", bus.imem_addr, 32'h0060_0004);
      drv(0, 0, 0, 1, 0, 32'h0060_000a, 32'h4444_4444);
      drv(0, 0, 0, 0, 1, 32'h0060_000a, 0);
      chk("mis_valid", bus.if_valid, 1);
      chk("mis_fault", bus.if_fault, 0);
      chk("mis_pc", bus.if_pc, 32'h0060_0006);
      chk("mis_instr", bus.if_instr, 32'h4444_4444);
`endif

      // random traffic against a memory-side model
      drv(1, 0, 0, 0, 0, RPC, 0);
      pc_reg = RPC; mem_out = 0; mem_drop = 0; mem_pc = 0;
      q_pc.delete(); q_in.delete();
      for (int c = 0; c < 3000; c++) begin
         f  = ($urandom % 16) == 0;
         g  = $urandom % 2;
         y  = ($urandom % 3) != 0;
         v  = mem_out ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
         rd = $urandom;
         drv(0, f, g, v, y, pc_reg, rd);
         exp_req = !f && !mem_out && (q_pc.size() < DEPTH);
         chk("r_req", bus.imem_req, exp_req);
         if (exp_req) chk("r_addr", bus.imem_addr, pc_reg);
         chk("r_pwe", bus.pc_write_enable, (exp_req & g) | f);
         chk("r_valid", bus.if_valid, q_pc.size() != 0);
         if (q_pc.size() != 0) begin
            chk("r_pc", bus.if_pc, q_pc[0]);
            chk("r_instr", bus.if_instr, q_in[0]);
         end else begin
            chk("r_idle_pc", bus.if_pc, RPC);
            chk("r_idle_instr", bus.if_instr, 0);
         end
         if (f) begin
            q_pc.delete(); q_in.delete();
            if (mem_out && !v) mem_drop = 1;
         end else begin
            if (q_pc.size() != 0 && y) begin
               void'(q_pc.pop_front());
               void'(q_in.pop_front());
            end
            if (v && mem_out && !mem_drop) begin
               q_pc.push_back(mem_pc);
               q_in.push_back(rd);
            end
         end
         if (v) begin
            mem_out = 0;
            mem_drop = 0;
         end
         if (exp_req && g) begin
            mem_out = 1;
            mem_pc = pc_reg;
         end
         if (f) pc_reg = RPC + ($urandom_range(0, 1023) << 2);
         else if (exp_req && g) pc_reg = pc_reg + 4;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
